// File: rtl/ahb_lite_sram_slave_pkg.sv
// Shared AHB-Lite types and helpers for the SRAM slave.
//   htrans_e : transfer type encodings
//   hsize_e  : transfer size encodings
//   hresp_e  : response encodings
//   state_e  : slave FSM states
//   lane_mask: byte-lane enable for a given size and byte offset
package AHB_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    SIZE_BYTE  = 3'd0,
    SIZE_HALF  = 3'd1,
    SIZE_WORD  = 3'd2,
    SIZE_DWORD = 3'd3
  } hsize_e;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // Up to 8 byte lanes (64-bit bus); callers slice to their lane count.
  // Sizes above dword are flagged as errors elsewhere, so they are clamped here.
  function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] offset);
    logic [7:0] m;
    case (size)
      3'd0:    m = 8'h01;
      3'd1:    m = 8'h03;
      3'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << offset;
  endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// Word-organised SRAM array with per-byte write enables.
//   clk   : write clock
//   we    : write strobe
//   be    : byte-lane enables (bit i covers wdata[8i+7:8i])
//   addr  : word index, shared by read and write
//   wdata : write data
//   rdata : asynchronous read of mem[addr]
module ahb_sram_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [DATA_W/8-1:0]      be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < DATA_W/8; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave in front of an SRAM, with configurable wait states and
// two-cycle ERROR response for out-of-range, misaligned or oversize transfers.
//   hclk, hresetn      : clock, synchronous active-low reset
//   hsel, haddr, htrans, hwrite, hsize, hburst, hready : address phase inputs
//   hwdata             : write data (data phase)
//   hrdata, hreadyout, hresp : data phase outputs
module ahb_lite_sram_slave
  import AHB_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic              hready,
  input  logic [DATA_W-1:0] hwdata,
  output logic [DATA_W-1:0] hrdata,
  output logic              hreadyout,
  output logic              hresp
);

  localparam int          NB    = DATA_W / 8;
  localparam int          OFF_W = $clog2(NB);
  localparam int          IDX_W = $clog2(DEPTH);
  localparam longint unsigned MEM_BYTES = longint'(DEPTH) * longint'(NB);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [NB-1:0]     be_q;
  logic              write_q;
  logic [DATA_W-1:0] mem_rdata;
  hresp_e            resp;

  logic              accept, err;
  logic [7:0]        mask;
  int unsigned       size_bytes;

  // hburst carries no meaning for a single-port SRAM.
  logic unused_hburst;
  assign unused_hburst = ^hburst;

  always_comb begin
    size_bytes = 32'd1 << hsize;
    err = (size_bytes > 32'(NB))
       || ((32'(haddr[OFF_W-1:0]) & (size_bytes - 32'd1)) != 32'd0)
       || (64'(haddr) >= MEM_BYTES);
    mask = lane_mask(hsize, 3'(haddr[OFF_W-1:0]));
    // A new address phase is only taken while this slave is itself ready.
    accept = hsel && hready && hreadyout && (htrans == TRANS_NONSEQ || htrans == TRANS_SEQ);
  end

  always_comb begin
    state_d   = state_q;
    hreadyout = 1'b1;
    resp      = RESP_OKAY;
    case (state_q)
      ST_WAIT: begin
        hreadyout = 1'b0;
        if (cnt_q <= 3'd1) state_d = ST_DATA;
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        resp      = RESP_ERROR;
        state_d   = ST_ERR2;
      end
      default: begin
        if (state_q == ST_ERR2) resp = RESP_ERROR;
        if (!accept)                state_d = ST_IDLE;
        else if (err)               state_d = ST_ERR1;
        else if (WAIT_STATES > 0)   state_d = ST_WAIT;
        else                        state_d = ST_DATA;
      end
    endcase
  end

  assign hresp = resp;

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      be_q    <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_q   <= haddr[OFF_W +: IDX_W];
        be_q    <= mask[NB-1:0];
        write_q <= hwrite;
      end
      if (accept && !err && WAIT_STATES > 0) cnt_q <= 3'(WAIT_STATES);
      else if (state_q == ST_WAIT)           cnt_q <= cnt_q - 3'd1;
    end
  end

  // Write lands on the final (ready) data-phase edge; a reset on that edge cancels it.
  ahb_sram_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (hclk),
    .we    (hresetn && write_q && state_q == ST_DATA),
    .be    (be_q),
    .addr  (idx_q),
    .wdata (hwdata),
    .rdata (mem_rdata)
  );

  assign hrdata = (!write_q && (state_q == ST_WAIT || state_q == ST_DATA)) ? mem_rdata : '0;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
module tb_ahb_lite_sram_slave;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hsel = 1'b0;
  logic        sel3 = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = '0;
  logic [2:0]  hburst = '0;
  logic [31:0] hwdata = '0;
  logic        hready;

  logic [31:0] hrdata0, hrdata3;
  logic        hro0, hro3, hresp0, hresp3;
  logic        hsel0, hsel3;

  int tests = 0;
  int fails = 0;
  int n;

  always #5 hclk = ~hclk;

  assign hsel0  = hsel && !sel3;
  assign hsel3  = hsel && sel3;
  assign hready = sel3 ? hro3 : hro0;

  ahb_lite_sram_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_STATES(0)) dut0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hready(hready), .hwdata(hwdata),
    .hrdata(hrdata0), .hreadyout(hro0), .hresp(hresp0)
  );

  ahb_lite_sram_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_STATES(3)) dut3 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hready(hready), .hwdata(hwdata),
    .hrdata(hrdata3), .hreadyout(hro3), .hresp(hresp3)
  );

  task automatic step();
    @(negedge hclk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic addr_ph(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [1:0] tr);
    hsel = 1'b1; haddr = a; hwrite = w; hsize = sz; htrans = tr;
  endtask

  task automatic idle_bus();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
  endtask

  // Counts hreadyout-low cycles of the WAIT_STATES=3 slave, bounded.
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (hro3 !== 1'b1 && cnt < 20) begin
      cnt++;
      step();
    end
  endtask

  initial begin
    hburst = 3'b001;
    step(); step();
    chk("reset hreadyout0", 32'(hro0), 32'd1);
    chk("reset hresp0", 32'(hresp0), 32'd0);
    chk("reset hrdata0", hrdata0, 32'h0);
    chk("reset hreadyout3", 32'(hro3), 32'd1);
    chk("reset hrdata3", hrdata3, 32'h0);
    hresetn = 1'b1;
    step();

    // Word write then SEQ read back-to-back, zero wait
    addr_ph(32'h10, 1'b1, 3'd2, 2'b10); step();
    chk("wr data phase ready", 32'(hro0), 32'd1);
    chk("wr data phase hrdata", hrdata0, 32'h0);
    hwdata = 32'hDEADBEEF;
    addr_ph(32'h10, 1'b0, 3'd2, 2'b11); step();
    chk("rd data phase ready", 32'(hro0), 32'd1);
    chk("rd data phase resp", 32'(hresp0), 32'd0);
    chk("rd after wr", hrdata0, 32'hDEADBEEF);
    idle_bus(); step();
    chk("idle hrdata", hrdata0, 32'h0);

    // Byte and halfword lanes
    addr_ph(32'h10, 1'b1, 3'd2, 2'b10); step();
    hwdata = 32'h0;
    addr_ph(32'h13, 1'b1, 3'd0, 2'b10); step();
    hwdata = 32'hAAAAAAAA;
    addr_ph(32'h10, 1'b0, 3'd2, 2'b10); step();
    chk("byte lane 3", hrdata0, 32'hAA000000);
    addr_ph(32'h10, 1'b1, 3'd1, 2'b10); step();
    hwdata = 32'h55665566;
    addr_ph(32'h10, 1'b0, 3'd2, 2'b10); step();
    chk("half lanes 0-1", hrdata0, 32'hAA005566);
    idle_bus(); step();

    // Out-of-range read
    addr_ph(32'h400, 1'b0, 3'd2, 2'b10); step();
    idle_bus();
    chk("oob err1 ready", 32'(hro0), 32'd0);
    chk("oob err1 resp", 32'(hresp0), 32'd1);
    step();
    chk("oob err2 ready", 32'(hro0), 32'd1);
    chk("oob err2 resp", 32'(hresp0), 32'd1);
    chk("oob err2 hrdata", hrdata0, 32'h0);
    step();
    chk("after err resp", 32'(hresp0), 32'd0);

    // Misaligned halfword write must not touch memory
    addr_ph(32'h11, 1'b1, 3'd1, 2'b10); step();
    idle_bus();
    hwdata = 32'hFFFFFFFF;
    chk("misalign err1 ready", 32'(hro0), 32'd0);
    chk("misalign err1 resp", 32'(hresp0), 32'd1);
    step();
    chk("misalign err2 resp", 32'(hresp0), 32'd1);
    addr_ph(32'h10, 1'b0, 3'd2, 2'b10); step();
    chk("mem unchanged", hrdata0, 32'hAA005566);
    chk("readback resp", 32'(hresp0), 32'd0);

    // Oversize (dword on 32-bit bus)
    addr_ph(32'h10, 1'b0, 3'd3, 2'b10); step();
    idle_bus();
    chk("dword err1 resp", 32'(hresp0), 32'd1);
    step(); step();

    // IDLE/BUSY with hsel: zero-wait OKAY, no access
    addr_ph(32'h10, 1'b1, 3'd2, 2'b01); step();
    chk("busy ready", 32'(hro0), 32'd1);
    idle_bus(); step();

    // Wait-state slave
    sel3 = 1'b1;
    addr_ph(32'h20, 1'b1, 3'd2, 2'b10); step();
    idle_bus();
    hwdata = 32'h12345678;
    wait_ready(n);
    chk("ws3 write low cycles", 32'(n), 32'd3);
    chk("ws3 write resp", 32'(hresp3), 32'd0);
    addr_ph(32'h20, 1'b0, 3'd2, 2'b10); step();
    idle_bus();
    wait_ready(n);
    chk("ws3 read low cycles", 32'(n), 32'd3);
    chk("ws3 read data", hrdata3, 32'h12345678);
    chk("ws3 read resp", 32'(hresp3), 32'd0);
    step();

    // Reset during WAIT aborts the pending write
    addr_ph(32'h20, 1'b1, 3'd2, 2'b10); step();
    idle_bus();
    hwdata = 32'hCAFEF00D;
    chk("ws3 in wait", 32'(hro3), 32'd0);
    hresetn = 1'b0; step();
    chk("abort ready", 32'(hro3), 32'd1);
    chk("abort resp", 32'(hresp3), 32'd0);
    chk("abort hrdata", hrdata3, 32'h0);
    hresetn = 1'b1;
    addr_ph(32'h20, 1'b0, 3'd2, 2'b10); step();
    idle_bus();
    wait_ready(n);
    chk("post-abort low cycles", 32'(n), 32'd3);
    chk("aborted write absent", hrdata3, 32'h12345678);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
